// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
// Shares one 8-bit SPI bus among NREQ local requesters, one slave per
// requester. Requests are served round-robin. Each transfer is one
// full-duplex byte sent LSB-first. SCLK idles low. The slave drives SDO on
// the SCLK rise and samples SDI on the fall, so MOSI changes on the rise and
// MISO is captured on the fall.
//
// Ports
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   req      per-requester transfer request (level)
//   tx_data  byte for requester i at [8i+7:8i], sampled at grant
//   grant    one-hot, high for the whole transfer of the served requester
//   done     one-cycle pulse at transfer end
//   rx_data  received byte, valid with done, held until the next done
//   busy     high whenever the FSM is not idle
//   SCLK     SPI clock, idle low, half-period CLK_DIV cycles
//   CS       active-low chip selects, at most one low
//   MOSI     serial data to slave SDI
//   MISO     serial data from slave SDO
//
// state | meaning
// IDLE  | bus free, arbitrate among req
// SETUP | CS low, SCLK low, MOSI = bit0, CLK_DIV cycles
// HIGH  | SCLK high, CLK_DIV cycles
// LOW   | SCLK low after falls 1..7, CLK_DIV cycles
// HOLD  | SCLK low after the 8th fall, CS still low, CLK_DIV cycles
// DONE  | CS released, done pulse, rx_data updated
module spi_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] tx_data,
  output logic [NREQ-1:0]   grant,
  output logic              done,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              SCLK,
  output logic [NREQ-1:0]   CS,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] DIV_M1 = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [7:0]      tx_shift, tx_shift_nxt;
  logic [7:0]      rx_shift, rx_shift_nxt;
  logic [NREQ-1:0] grant_nxt, cs_nxt;
  logic            sclk_nxt, mosi_nxt, done_nxt;
  logic [7:0]      rx_data_nxt;
  logic            sel_vld;
  int              sel_idx;
  logic            tc;

  assign busy = (state != S_IDLE);
  assign tc   = (timer == '0);

  // Round-robin pick: first requester at or after the pointer.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (!sel_vld && req[(int'(ptr) + j) % NREQ]) begin
        sel_vld = 1'b1;
        sel_idx = (int'(ptr) + j) % NREQ;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = tc ? timer : timer - TW'(1);
    bit_cnt_nxt  = bit_cnt;
    ptr_nxt      = ptr;
    tx_shift_nxt = tx_shift;
    rx_shift_nxt = rx_shift;
    grant_nxt    = grant;
    cs_nxt       = CS;
    sclk_nxt     = SCLK;
    mosi_nxt     = MOSI;
    done_nxt     = 1'b0;
    rx_data_nxt  = rx_data;
    case (state)
      S_IDLE: begin
        if (sel_vld) begin
          state_nxt            = S_SETUP;
          timer_nxt            = DIV_M1;
          bit_cnt_nxt          = '0;
          ptr_nxt              = IW'((sel_idx + 1) % NREQ);
          grant_nxt            = '0;
          grant_nxt[sel_idx]   = 1'b1;
          cs_nxt               = '1;
          cs_nxt[sel_idx]      = 1'b0;
          tx_shift_nxt         = tx_data[8*sel_idx +: 8];
          mosi_nxt             = tx_data[8*sel_idx];
        end
      end
      // bit_cnt counts completed falls, so it indexes the bit to present
      // on the coming rise.
      S_SETUP, S_LOW: begin
        if (tc) begin
          state_nxt = S_HIGH;
          timer_nxt = DIV_M1;
          sclk_nxt  = 1'b1;
          mosi_nxt  = tx_shift[bit_cnt];
        end
      end
      S_HIGH: begin
        if (tc) begin
          state_nxt    = (bit_cnt == 3'd7) ? S_HOLD : S_LOW;
          timer_nxt    = DIV_M1;
          sclk_nxt     = 1'b0;
          rx_shift_nxt = {MISO, rx_shift[7:1]};
          bit_cnt_nxt  = bit_cnt + 3'd1;
        end
      end
      S_HOLD: begin
        if (tc) begin
          state_nxt   = S_DONE;
          grant_nxt   = '0;
          cs_nxt      = '1;
          mosi_nxt    = 1'b0;
          done_nxt    = 1'b1;
          rx_data_nxt = rx_shift;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      ptr      <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      grant    <= '0;
      CS       <= '1;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      bit_cnt  <= bit_cnt_nxt;
      ptr      <= ptr_nxt;
      tx_shift <= tx_shift_nxt;
      rx_shift <= rx_shift_nxt;
      grant    <= grant_nxt;
      CS       <= cs_nxt;
      SCLK     <= sclk_nxt;
      MOSI     <= mosi_nxt;
      done     <= done_nxt;
      rx_data  <= rx_data_nxt;
    end
  end

endmodule
